// File: rtl/mul_cs32_seq_if.sv
// ---------------------------------------------------------------------------
// mul_cs32_seq_if
// Handshake bundle for the sequential 32x32 carry-save multiplier.
//   in_valid  : producer has operands on op1/op2
//   in_ready  : multiplier can take operands (idle)
//   op1, op2  : unsigned multiplicand / multiplier
//   out_valid : prod holds a finished product
//   out_ready : consumer takes the product
//   prod      : 64-bit product, stable while out_valid is high
// The master modport is the side that supplies operands and consumes results;
// the slave modport is the multiplier itself.
// ---------------------------------------------------------------------------
interface mul_cs32_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] prod;

    modport master (
        output in_valid, op1, op2, out_ready,
        input  in_ready, out_valid, prod
    );

    modport slave (
        input  in_valid, op1, op2, out_ready,
        output in_ready, out_valid, prod
    );
endinterface

// File: rtl/mul_cs32_seq.sv
// ---------------------------------------------------------------------------
// mul_cs32_seq
// Sequential 32x32 unsigned multiplier. One partial product per cycle is
// folded into a redundant sum/carry pair through a 3:2 carry-save stage, so
// each RUN cycle costs one full-adder level. After 32 iterations the pair is
// resolved by a single 32-bit lookahead add into the high product word.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, discards any in-flight operation
//   bus : mul_cs32_seq_if.slave (operand and product handshakes)
// ---------------------------------------------------------------------------
module mul_cs32_seq (
    input  logic               clk,
    input  logic               rst,
    mul_cs32_seq_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESOLVE,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] s_q;
    logic [31:0] c_q;
    logic [31:0] l_q;
    logic [31:0] h_q;
    logic [4:0]  cnt;

    logic [31:0] pp;
    logic [31:0] csa_s;
    logic [31:0] csa_c;

    logic [31:0] gen;
    logic [31:0] prp;
    logic [31:0] cla_sum;
    logic        cla_cout;

    // Partial product gated by the current multiplier LSB, then compressed
    // with the running sum/carry vectors by a plain 3:2 stage.
    assign pp    = a_q & {32{b_q[0]}};
    assign csa_s = s_q ^ c_q ^ pp;
    assign csa_c = (s_q & c_q) | (s_q & pp) | (c_q & pp);

    // Kogge-Stone style lookahead over S + C with no carry-in. After the five
    // prefix levels gen[i] is the carry out of bit i. Low bits of prp are
    // zeroed by the shift, but those bits are never consulted again at the
    // wider spans, so no mask is needed.
    always_comb begin
        gen = s_q & c_q;
        prp = s_q ^ c_q;
        for (int k = 0; k < 5; k++) begin
            gen = gen | (prp & (gen << (1 << k)));
            prp = prp & (prp << (1 << k));
        end
        cla_sum  = (s_q ^ c_q) ^ {gen[30:0], 1'b0};
        cla_cout = gen[31];
    end

    // Handshake flags come straight from the state so neither in_valid nor
    // out_ready has a combinational path to an output.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.prod      = {h_q, l_q};

    // Control and datapath. In RUN the sum vector shifts right by one with
    // its LSB retiring into L, while the carry vector stays put: its bit i
    // carries weight i+1, which lines up with weight i after the shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            l_q   <= '0;
            h_q   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.op1;
                        b_q   <= bus.op2;
                        s_q   <= '0;
                        c_q   <= '0;
                        l_q   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    l_q <= {csa_s[0], l_q[31:1]};
                    s_q <= {1'b0, csa_s[31:1]};
                    c_q <= csa_c;
                    b_q <= {1'b0, b_q[31:1]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    h_q   <= cla_sum;
                    state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
